unidade_controle_jogadas: RTL and testbench

- Moore FSM that sequences the multi-play memory-game datapath.
- Initialises the datapath, then waits for each play, registers it, compares it, and advances either the address counter or the limit counter.
- Ends the game on success, on a wrong play, or on timeout.
- Sits beside the datapath in the top level. Status inputs come from the datapath; counter and register control outputs go back to it.

---
 rtl/unidade_controle_jogadas_pkg.sv | 34 +++
 rtl/unidade_controle_jogadas.sv | 123 ++++++++++++
 tb/tb_unidade_controle_jogadas.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unidade_controle_jogadas_pkg.sv
// Shared definitions for the multi-play memory-game control unit.
//   estado_t   : 4-bit state codes, also shown raw on db_estado
//   controle_t : bundle of the control/status strobes decoded per state
package unidade_controle_jogadas_pkg;

    typedef enum logic [3:0] {
        INICIAL           = 4'h0,
        PREPARACAO        = 4'h1,
        ESPERA_JOGADA     = 4'h2,
        REGISTRA          = 4'h4,
        COMPARACAO        = 4'h5,
        PROXIMA_JOGADA    = 4'h6,
        PROXIMA_SEQUENCIA = 4'h7,
        FIM_ACERTOU       = 4'hA,
        FIM_TIMEOUT       = 4'hD,
        FIM_ERROU         = 4'hE
    } estado_t;

    typedef struct packed {
        logic zeraR;
        logic registraR;
        logic zeraE;
        logic contaE;
        logic zeraL;
        logic contaL;
        logic pronto;
        logic acertou;
        logic errou;
        logic deu_timeout;
    } controle_t;

    localparam controle_t CONTROLE_NENHUM = '0;

endpackage

// File: rtl/unidade_controle_jogadas.sv
// Moore control FSM for the multi-play memory game.
// Initialises the datapath, then per play: waits, registers, compares and
// advances either the address counter (next play) or the limit counter
// (next round). Ends on win, wrong play or (optionally) timeout.
//
// Ports:
//   clock, reset            : rising-edge clock, async active-high reset
//   iniciar                 : start/restart (only seen in inicial / fim_*)
//   jogada_feita            : one-cycle button-press pulse
//   chavesIgualMemoria      : registered play equals ROM data
//   enderecoIgualLimite     : address counter equals limit counter
//   fimL                    : last round reached
//   timeout                 : play-wait timeout
//   zeraR/registraR         : play register clear/load
//   zeraE/contaE            : address counter clear/increment
//   zeraL/contaL            : limit counter clear/increment
//   pronto/acertou/errou/deu_timeout : end-of-game status
//   db_estado               : raw state code for debug display
module unidade_controle_jogadas
    import unidade_controle_jogadas_pkg::*;
#(
    parameter bit TIMEOUT_EN = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       chavesIgualMemoria,
    input  logic       enderecoIgualLimite,
    input  logic       fimL,
    input  logic       timeout,
    output logic       zeraR,
    output logic       registraR,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       deu_timeout,
    output logic [3:0] db_estado
);

    estado_t   estado, proximo;
    controle_t ctl;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= INICIAL;
        else       estado <= proximo;
    end

    always_comb begin
        proximo = INICIAL;  // illegal codes recover to inicial
        case (estado)
            INICIAL:           proximo = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:        proximo = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                // a detected play takes priority over a simultaneous timeout
                if (jogada_feita)               proximo = REGISTRA;
                else if (timeout && TIMEOUT_EN) proximo = FIM_TIMEOUT;
                else                            proximo = ESPERA_JOGADA;
            end
            REGISTRA:          proximo = COMPARACAO;
            COMPARACAO: begin
                if (!chavesIgualMemoria)  proximo = FIM_ERROU;
                else if (enderecoIgualLimite)
                    proximo = fimL ? FIM_ACERTOU : PROXIMA_SEQUENCIA;
                else                      proximo = PROXIMA_JOGADA;
            end
            PROXIMA_JOGADA:    proximo = ESPERA_JOGADA;
            PROXIMA_SEQUENCIA: proximo = ESPERA_JOGADA;
            FIM_ACERTOU,
            FIM_ERROU,
            FIM_TIMEOUT:       proximo = iniciar ? PREPARACAO : estado;
            default:           proximo = INICIAL;
        endcase
    end

    always_comb begin
        ctl = CONTROLE_NENHUM;
        case (estado)
            PREPARACAO: begin
                ctl.zeraR = 1'b1;
                ctl.zeraE = 1'b1;
                ctl.zeraL = 1'b1;
            end
            REGISTRA:          ctl.registraR = 1'b1;
            PROXIMA_JOGADA:    ctl.contaE    = 1'b1;
            PROXIMA_SEQUENCIA: begin
                // new round restarts the address walk from zero
                ctl.contaL = 1'b1;
                ctl.zeraE  = 1'b1;
            end
            FIM_ACERTOU: begin
                ctl.pronto  = 1'b1;
                ctl.acertou = 1'b1;
            end
            FIM_ERROU: begin
                ctl.pronto = 1'b1;
                ctl.errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                ctl.pronto      = 1'b1;
                ctl.deu_timeout = 1'b1;
            end
            default: ctl = CONTROLE_NENHUM;
        endcase
    end

    assign zeraR       = ctl.zeraR;
    assign registraR   = ctl.registraR;
    assign zeraE       = ctl.zeraE;
    assign contaE      = ctl.contaE;
    assign zeraL       = ctl.zeraL;
    assign contaL      = ctl.contaL;
    assign pronto      = ctl.pronto;
    assign acertou     = ctl.acertou;
    assign errou       = ctl.errou;
    assign deu_timeout = ctl.deu_timeout;
    assign db_estado   = estado;

endmodule

// File: tb/tb_unidade_controle_jogadas.sv
// Bench for unidade_controle_jogadas: one instance with timeout enabled,
// one with it disabled, both fed the same inputs and tracked by a small
// behavioural model of the game flow.
module tb_unidade_controle_jogadas;

    logic clock = 1'b0;
    logic reset, iniciar, jogada_feita, ch_igual, end_igual, fimL, timeout;

    logic zeraR_t, registraR_t, zeraE_t, contaE_t, zeraL_t, contaL_t;
    logic pronto_t, acertou_t, errou_t, deu_timeout_t;
    logic [3:0] db_t;
    logic zeraR_n, registraR_n, zeraE_n, contaE_n, zeraL_n, contaL_n;
    logic pronto_n, acertou_n, errou_n, deu_timeout_n;
    logic [3:0] db_n;

    // {zeraR, registraR, zeraE, contaE, zeraL, contaL, pronto, acertou, errou, deu_timeout}
    wire [9:0] o_t = {zeraR_t, registraR_t, zeraE_t, contaE_t, zeraL_t, contaL_t,
                      pronto_t, acertou_t, errou_t, deu_timeout_t};
    wire [9:0] o_n = {zeraR_n, registraR_n, zeraE_n, contaE_n, zeraL_n, contaL_n,
                      pronto_n, acertou_n, errou_n, deu_timeout_n};

    int n_chk = 0;
    int n_fail = 0;
    int ms_t = 0;  // model state, timeout enabled
    int ms_n = 0;  // model state, timeout disabled
    logic [9:0] exp_tbl [16];

    always #5 clock = ~clock;

    unidade_controle_jogadas #(.TIMEOUT_EN(1'b1)) dut_t (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
        .chavesIgualMemoria(ch_igual), .enderecoIgualLimite(end_igual), .fimL(fimL),
        .timeout(timeout), .zeraR(zeraR_t), .registraR(registraR_t), .zeraE(zeraE_t),
        .contaE(contaE_t), .zeraL(zeraL_t), .contaL(contaL_t), .pronto(pronto_t),
        .acertou(acertou_t), .errou(errou_t), .deu_timeout(deu_timeout_t), .db_estado(db_t));

    unidade_controle_jogadas #(.TIMEOUT_EN(1'b0)) dut_n (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
        .chavesIgualMemoria(ch_igual), .enderecoIgualLimite(end_igual), .fimL(fimL),
        .timeout(timeout), .zeraR(zeraR_n), .registraR(registraR_n), .zeraE(zeraE_n),
        .contaE(contaE_n), .zeraL(zeraL_n), .contaL(contaL_n), .pronto(pronto_n),
        .acertou(acertou_n), .errou(errou_n), .deu_timeout(deu_timeout_n), .db_estado(db_n));

    // Game-flow rules expressed directly on state codes.
    function automatic int mnext(int s, bit en);
        case (s)
            'h0: return iniciar ? 'h1 : 'h0;
            'h1: return 'h2;
            'h2: return jogada_feita ? 'h4 : ((timeout && en) ? 'hD : 'h2);
            'h4: return 'h5;
            'h5: begin
                if (!ch_igual) return 'hE;
                if (end_igual) return fimL ? 'hA : 'h7;
                return 'h6;
            end
            'h6, 'h7: return 'h2;
            'hA, 'hD, 'hE: return iniciar ? 'h1 : s;
            default: return 'h0;
        endcase
    endfunction

    task automatic drive(input bit ini, jf, ch, ei, fl, to);
        iniciar = ini; jogada_feita = jf; ch_igual = ch;
        end_igual = ei; fimL = fl; timeout = to;
    endtask

    task automatic tick();
        @(posedge clock);
        ms_t = mnext(ms_t, 1'b1);
        ms_n = mnext(ms_n, 1'b0);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #12;
        n_chk++;
        if (db_t !== 4'h0 || o_t !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_hold: db=%h out=%b, want db=0 out=0", db_t, o_t);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        ms_t = 0; ms_n = 0;
        tick();
        n_chk++;
        if (db_t !== 4'h0 || db_n !== 4'h0 || o_t !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_idle: db=%h/%h out=%b, want 0/0 0", db_t, db_n, o_t);
        end
    endtask

    task automatic test_start();
        drive(1, 0, 0, 0, 0, 0);
        tick();
        n_chk++;
        if (db_t !== 4'h1 || o_t !== 10'b1010100000) begin
            n_fail++;
            $display("FAIL start_prep: db=%h out=%b, want 1 1010100000", db_t, o_t);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        n_chk++;
        if (db_t !== 4'h2 || o_t !== 10'b0) begin
            n_fail++;
            $display("FAIL start_wait: db=%h out=%b, want 2 0", db_t, o_t);
        end
    endtask

    // Play through registra/comparacao and check the state after comparacao.
    task automatic play(input bit ch, ei, fl, input logic [3:0] want, input logic [9:0] want_o,
                        input string nm);
        drive(0, 1, ch, ei, fl, 0);
        tick();
        n_chk++;
        if (db_t !== 4'h4 || o_t !== 10'b0100000000) begin
            n_fail++;
            $display("FAIL %s_reg: db=%h out=%b, want 4 0100000000", nm, db_t, o_t);
        end
        drive(0, 0, ch, ei, fl, 0);
        tick();
        n_chk++;
        if (db_t !== 4'h5 || o_t !== 10'b0) begin
            n_fail++;
            $display("FAIL %s_cmp: db=%h out=%b, want 5 0", nm, db_t, o_t);
        end
        tick();
        n_chk++;
        if (db_t !== want || o_t !== want_o) begin
            n_fail++;
            $display("FAIL %s_dec: db=%h out=%b, want %h %b", nm, db_t, o_t, want, want_o);
        end
    endtask

    task automatic test_next_round();
        play(1, 1, 0, 4'h7, 10'b0010010000, "next_round");
        tick();
        n_chk++;
        if (db_t !== 4'h2 || contaL_t !== 1'b0) begin
            n_fail++;
            $display("FAIL next_round_back: db=%h contaL=%b, want 2 0", db_t, contaL_t);
        end
    endtask

    task automatic test_mid_round();
        play(1, 0, 0, 4'h6, 10'b0001000000, "mid_round");
        tick();
        n_chk++;
        if (db_t !== 4'h2 || contaE_t !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_round_back: db=%h contaE=%b, want 2 0", db_t, contaE_t);
        end
    endtask

    task automatic test_async_reset();
        // still in espera_jogada here; reset lands between clock edges
        reset = 1'b1;
        #1;
        n_chk++;
        if (db_t !== 4'h0 || o_t !== 10'b0 || pronto_t !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: db=%h out=%b, want 0 0", db_t, o_t);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        ms_t = 0; ms_n = 0;
        test_start();
    endtask

    task automatic test_mismatch();
        play(0, 0, 0, 4'hE, 10'b0000001010, "mismatch");
        tick();
        n_chk++;
        if (db_t !== 4'hE || errou_t !== 1'b1 || pronto_t !== 1'b1) begin
            n_fail++;
            $display("FAIL mismatch_hold: db=%h errou=%b pronto=%b, want E 1 1", db_t, errou_t, pronto_t);
        end
        test_start();
    endtask

    task automatic test_win();
        play(1, 1, 1, 4'hA, 10'b0000001100, "win");
        drive(0, 1, 0, 0, 0, 1);  // ignored in end state
        tick();
        n_chk++;
        if (db_t !== 4'hA || acertou_t !== 1'b1) begin
            n_fail++;
            $display("FAIL win_hold: db=%h acertou=%b, want A 1", db_t, acertou_t);
        end
        test_start();
    endtask

    task automatic test_timeout();
        drive(0, 0, 0, 0, 0, 1);
        tick();
        n_chk++;
        if (db_t !== 4'hD || o_t !== 10'b0000001001) begin
            n_fail++;
            $display("FAIL timeout_en: db=%h out=%b, want D 0000001001", db_t, o_t);
        end
        n_chk++;
        if (db_n !== 4'h2 || o_n !== 10'b0) begin
            n_fail++;
            $display("FAIL timeout_dis: db=%h out=%b, want 2 0", db_n, o_n);
        end
        // iniciar restarts the timed-out game but is ignored while waiting
        drive(1, 0, 0, 0, 0, 0);
        tick();
        n_chk++;
        if (db_t !== 4'h1 || db_n !== 4'h2) begin
            n_fail++;
            $display("FAIL timeout_restart: db=%h/%h, want 1/2", db_t, db_n);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_simultaneous();
        drive(0, 1, 1, 0, 0, 1);
        tick();
        n_chk++;
        if (db_t !== 4'h4 || db_n !== 4'h4) begin
            n_fail++;
            $display("FAIL simultaneous: db=%h/%h, want 4/4", db_t, db_n);
        end
        drive(0, 0, 1, 0, 0, 0);
        tick(); tick(); tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 5) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
            tick();
            n_chk++;
            if (db_t !== 4'(ms_t) || o_t !== exp_tbl[ms_t]) begin
                n_fail++;
                $display("FAIL random_en[%0d]: db=%h out=%b, want %h %b", i, db_t, o_t, ms_t[3:0], exp_tbl[ms_t]);
            end
            n_chk++;
            if (db_n !== 4'(ms_n) || o_n !== exp_tbl[ms_n]) begin
                n_fail++;
                $display("FAIL random_dis[%0d]: db=%h out=%b, want %h %b", i, db_n, o_n, ms_n[3:0], exp_tbl[ms_n]);
            end
            n_chk++;
            if ((contaE_t && contaL_t) || (contaE_n && contaL_n)) begin
                n_fail++;
                $display("FAIL random_excl[%0d]: contaE/contaL = %b%b %b%b, want never both", i,
                         contaE_t, contaL_t, contaE_n, contaL_n);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) exp_tbl[k] = 10'b0;
        exp_tbl['h1] = 10'b1010100000;
        exp_tbl['h4] = 10'b0100000000;
        exp_tbl['h6] = 10'b0001000000;
        exp_tbl['h7] = 10'b0010010000;
        exp_tbl['hA] = 10'b0000001100;
        exp_tbl['hD] = 10'b0000001001;
        exp_tbl['hE] = 10'b0000001010;

        test_reset();
        test_start();
        test_next_round();
        test_mid_round();
        test_async_reset();
        test_mismatch();
        test_win();
        test_simultaneous();
        test_timeout();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
